alarm_time_setter: RTL
======================

Name: alarm_time_setter

Overview:
- Button-driven front-end that produces the load interface of the alarm clock core: BCD H_in1/H_in0/M_in1/M_in0 plus LD_time/LD_alarm strobes.
- Four raw push-buttons are synchronised, debounced and converted to one-cycle press events.
- An edit FSM steps through hours then minutes, with BCD wrap, and commits with a timed load strobe.
- Time edits start from the clock core's current display; alarm edits start from the last committed alarm.

Parameters:
- DB_CYCLES, 4, consecutive stable synchronised samples required to accept a new button level (1..255).
- LD_HOLD, 2, cycles LD_time/LD_alarm is held high on commit (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_time  input  1  raw button; enter time edit.
- btn_alarm  input  1  raw button; enter alarm edit.
- btn_inc  input  1  raw button; increment the active field.
- btn_next  input  1  raw button; advance field / commit.
- H_out1  input  2  current clock hour tens, BCD.
- H_out0  input  4  current clock hour units, BCD.
- M_out1  input  4  current clock minute tens, BCD.
- M_out0  input  4  current clock minute units, BCD.
- H_in1  output  2  hour tens to clock core.
- H_in0  output  4  hour units to clock core.
- M_in1  output  4  minute tens to clock core.
- M_in0  output  4  minute units to clock core.
- LD_time  output  1  load-time strobe.
- LD_alarm  output  1  load-alarm strobe.
- edit_state  output  2  00 IDLE, 01 EDIT_H, 10 EDIT_M, 11 COMMIT.
- tgt_alarm  output  1  1 while the current or last edit targets the alarm.

Behaviour:
- Reset (asynchronous, immediate): all H_in/M_in = 0; LD_time = LD_alarm = 0; edit_state = 00; tgt_alarm = 0; internal alarm shadow = 00:00; debouncers cleared to level 0; all counters cleared.
- Input conditioning, per button:
  - 2-FF synchroniser, then a counter that accepts a new level after DB_CYCLES consecutive differing samples. Any sample equal to the current level clears the counter.
  - A press event is a one-cycle pulse on the debounced 0->1 transition. Release generates no event.
  - Latency: for a clean input that rises and stays high, the event is high in the cycle ending at the (DB_CYCLES+2)-th rising edge after the first edge that samples it high.
- FSM:
  - IDLE:
    - time event -> EDIT_H, tgt_alarm = 0, H_in/M_in loaded from H_out*/M_out*.
    - alarm event -> EDIT_H, tgt_alarm = 1, H_in/M_in loaded from the alarm shadow.
    - Simultaneous time and alarm events: time wins.
    - inc/next events are ignored in IDLE.
  - EDIT_H:
    - inc: hour +1 in BCD, 09->10, 19->20, 23->00.
    - next -> EDIT_M.
  - EDIT_M:
    - inc: minute +1 in BCD, x9->(x+1)0, 59->00. No carry into hours.
    - next -> COMMIT.
  - COMMIT:
    - LD_time (tgt_alarm = 0) or LD_alarm (tgt_alarm = 1) is high for exactly LD_HOLD cycles starting the cycle after entry; then -> IDLE.
    - Alarm target: the shadow is updated on entry.
    - All button events are ignored.
  - inc and next in the same cycle: next wins, inc is dropped.
  - time/alarm events during EDIT_H, EDIT_M or COMMIT are ignored; no retargeting mid-edit.
- Outputs:
  - H_in/M_in are registered and hold their values in IDLE after a commit, stable throughout LD high.
  - Never simultaneously LD_time = LD_alarm = 1.
  - H_in1 never exceeds 2; H_in1 = 2 implies H_in0 <= 3; M_in1 <= 5; digits <= 9.
  - Out-of-range H_out* values are clamped to 00 on preload.
- Reset mid-edit or mid-COMMIT: aborts immediately, no LD completion, shadow returns to 00:00.

Test Plan:
- Reset asserted 10 cycles, released -> H_in = 00, M_in = 00, LD_time = LD_alarm = 0, edit_state = 00, tgt_alarm = 0.
- Clock core at 11:26; btn_time press; 3 inc; next; 40 inc; next -> preload 11:26, hours 14, minutes 06; LD_time high exactly 2 cycles with H_in = 14, M_in = 06; then edit_state = 00.
- Hour at 23, inc -> 00. Minute at 59, inc -> 00 with hour unchanged. Hour sweep covers 09->10 and 19->20.
- btn_alarm after reset (preload 00:00); set 11:30; commit -> LD_alarm 2 cycles, LD_time stays 0. Re-enter alarm edit -> preload 11:30.
- Bounce: btn_inc toggles every cycle for 12 cycles, then held high 10 cycles -> exactly one increment. A glitch shorter than DB_CYCLES -> no event.
- Simultaneous btn_time and btn_alarm in IDLE -> tgt_alarm = 0. Reset asserted on the 1st LD_time cycle -> LD_time drops immediately and stays 0, outputs 00:00, edit_state = 00.

Source files
------------

// File: rtl/alarm_time_setter.sv
`default_nettype none
// ============================================================================
// Module   : alarm_time_setter
// Function : Button-driven editor producing BCD load values and LD strobes
//            for the alarm clock core.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_time_setter #(
  parameter int DB_CYCLES = 4,
  parameter int LD_HOLD   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_time,
  input  logic       btn_alarm,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic [1:0] H_out1,
  input  logic [3:0] H_out0,
  input  logic [3:0] M_out1,
  input  logic [3:0] M_out0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic [1:0] edit_state,
  output logic       tgt_alarm
);

  localparam logic [7:0] c_DB_LAST = 8'(DB_CYCLES - 1);
  localparam logic [3:0] c_LD_LAST = 4'(LD_HOLD - 1);
  localparam int         c_B_TIME  = 0;
  localparam int         c_B_ALARM = 1;
  localparam int         c_B_INC   = 2;
  localparam int         c_B_NEXT  = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_EDIT_H = 2'b01,
    S_EDIT_M = 2'b10,
    S_COMMIT = 2'b11
  } state_t;

  logic [3:0] w_raw;
  logic [3:0] w_evt;

  assign w_raw = {btn_next, btn_inc, btn_alarm, btn_time};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      logic       r_sync1;
      logic       r_sync2;
      logic       r_lvl;
      logic [7:0] r_cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_lvl   <= 1'b0;
          r_cnt   <= 8'd0;
        end else begin
          r_sync1 <= w_raw[gi];
          r_sync2 <= r_sync1;
          if (r_sync2 == r_lvl) begin
            r_cnt <= 8'd0;
          end else if (r_cnt == c_DB_LAST) begin
            r_lvl <= r_sync2;
            r_cnt <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      end

      // Event fires in the cycle whose edge accepts the new high level.
      assign w_evt[gi] = r_sync2 & ~r_lvl & (r_cnt == c_DB_LAST);
    end
  endgenerate

  state_t     r_state;
  logic       r_tgt_alarm;
  logic [1:0] r_h1;
  logic [3:0] r_h0;
  logic [3:0] r_m1;
  logic [3:0] r_m0;
  logic [1:0] r_sh_h1;
  logic [3:0] r_sh_h0;
  logic [3:0] r_sh_m1;
  logic [3:0] r_sh_m0;
  logic [3:0] r_ld_cnt;
  logic       r_ld_time;
  logic       r_ld_alarm;

  logic       w_hr_ok;
  logic       w_mn_ok;
  logic [1:0] w_hr_inc_t;
  logic [3:0] w_hr_inc_u;
  logic [3:0] w_mn_inc_t;
  logic [3:0] w_mn_inc_u;

  assign w_hr_ok = ((H_out1 < 2'd2) && (H_out0 <= 4'd9)) ||
                   ((H_out1 == 2'd2) && (H_out0 <= 4'd3));
  assign w_mn_ok = (M_out1 <= 4'd5) && (M_out0 <= 4'd9);

  always_comb begin
    w_hr_inc_t = r_h1;
    w_hr_inc_u = r_h0 + 4'd1;
    if ((r_h1 == 2'd2) && (r_h0 == 4'd3)) begin
      w_hr_inc_t = 2'd0;
      w_hr_inc_u = 4'd0;
    end else if (r_h0 == 4'd9) begin
      w_hr_inc_t = r_h1 + 2'd1;
      w_hr_inc_u = 4'd0;
    end
  end

  always_comb begin
    w_mn_inc_t = r_m1;
    w_mn_inc_u = r_m0 + 4'd1;
    if (r_m0 == 4'd9) begin
      w_mn_inc_u = 4'd0;
      w_mn_inc_t = (r_m1 == 4'd5) ? 4'd0 : r_m1 + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tgt_alarm <= 1'b0;
      r_h1        <= 2'd0;
      r_h0        <= 4'd0;
      r_m1        <= 4'd0;
      r_m0        <= 4'd0;
      r_sh_h1     <= 2'd0;
      r_sh_h0     <= 4'd0;
      r_sh_m1     <= 4'd0;
      r_sh_m0     <= 4'd0;
      r_ld_cnt    <= 4'd0;
      r_ld_time   <= 1'b0;
      r_ld_alarm  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_evt[c_B_TIME]) begin
            r_state     <= S_EDIT_H;
            r_tgt_alarm <= 1'b0;
            r_h1        <= w_hr_ok ? H_out1 : 2'd0;
            r_h0        <= w_hr_ok ? H_out0 : 4'd0;
            r_m1        <= w_mn_ok ? M_out1 : 4'd0;
            r_m0        <= w_mn_ok ? M_out0 : 4'd0;
          end else if (w_evt[c_B_ALARM]) begin
            r_state     <= S_EDIT_H;
            r_tgt_alarm <= 1'b1;
            r_h1        <= r_sh_h1;
            r_h0        <= r_sh_h0;
            r_m1        <= r_sh_m1;
            r_m0        <= r_sh_m0;
          end
        end
        S_EDIT_H: begin
          if (w_evt[c_B_NEXT]) begin
            r_state <= S_EDIT_M;
          end else if (w_evt[c_B_INC]) begin
            r_h1 <= w_hr_inc_t;
            r_h0 <= w_hr_inc_u;
          end
        end
        S_EDIT_M: begin
          if (w_evt[c_B_NEXT]) begin
            r_state <= S_COMMIT;
            if (r_tgt_alarm) begin
              r_sh_h1 <= r_h1;
              r_sh_h0 <= r_h0;
              r_sh_m1 <= r_m1;
              r_sh_m0 <= r_m0;
            end
          end else if (w_evt[c_B_INC]) begin
            r_m1 <= w_mn_inc_t;
            r_m0 <= w_mn_inc_u;
          end
        end
        S_COMMIT: begin
          // First COMMIT cycle only arms the strobe; it then runs LD_HOLD cycles.
          if (!(r_ld_time || r_ld_alarm)) begin
            r_ld_time  <= ~r_tgt_alarm;
            r_ld_alarm <= r_tgt_alarm;
            r_ld_cnt   <= 4'd0;
          end else if (r_ld_cnt == c_LD_LAST) begin
            r_ld_time  <= 1'b0;
            r_ld_alarm <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_ld_cnt <= r_ld_cnt + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign H_in1      = r_h1;
  assign H_in0      = r_h0;
  assign M_in1      = r_m1;
  assign M_in0      = r_m0;
  assign LD_time    = r_ld_time;
  assign LD_alarm   = r_ld_alarm;
  assign edit_state = r_state;
  assign tgt_alarm  = r_tgt_alarm;

endmodule
`default_nettype wire
